// File: rtl/dkong_hiscore_ctrl.sv
// dkong_hiscore_ctrl -- moves the Donkey Kong hiscore table between game RAM
// and a 64x8 host-side buffer.
//
// Restore: wait for a vblank rising edge, optionally check the table signature,
//          then write buffer[0..LEN-1] into START_ADDR..START_ADDR+LEN-1.
// Save:    read START_ADDR..START_ADDR+LEN-1 into buffer[0..LEN-1] immediately.
// Each byte takes three cycles (X_ADDR, X_WAIT, X_DATA) with the address held;
// a restore write strobes in X_ADDR and a save samples game data in X_DATA.
//
// Optional feature macro: DKONG_HS_SIGCHK_EN
//   defined   -> SIG_A/SIG_B signature check with TIMEOUT_FRAMES give-up and O_ERR
//   undefined -> restore starts on the first vblank rising edge, O_ERR stays 0
//
// Ports:
//   I_CLK_24576M, I_RESET (sync, active high)
//   I_VBLANK                      vertical blank
//   I_RESTORE_REQ, I_SAVE_REQ     one-cycle start pulses (restore wins a tie)
//   O_BUSY, O_DONE, O_ERR         status
//   O_PAUSE                       CPU stall while the game-side port is in use
//   O_HS_*, I_HS_DATA_OUT         game-side hiscore RAM port
//   I_NV_ADDR/WR/DATA, O_NV_DATA  host-side buffer port (1-cycle read latency)
module dkong_hiscore_ctrl #(
  parameter logic [15:0] START_ADDR     = 16'h6100,
  parameter int          LEN            = 64,
  parameter logic [7:0]  SIG_FIRST      = 8'h00,
  parameter logic [7:0]  SIG_LAST       = 8'h00,
  parameter int          TIMEOUT_FRAMES = 255
) (
  input  logic        I_CLK_24576M,
  input  logic        I_RESET,
  input  logic        I_VBLANK,
  input  logic        I_RESTORE_REQ,
  input  logic        I_SAVE_REQ,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_ERR,
  output logic        O_PAUSE,
  output logic [15:0] O_HS_ADDRESS,
  output logic [7:0]  O_HS_DATA_IN,
  input  logic [7:0]  I_HS_DATA_OUT,
  output logic        O_HS_WRITE,
  output logic        O_HS_ACCESS,
  input  logic [5:0]  I_NV_ADDR,
  input  logic        I_NV_WR,
  input  logic [7:0]  I_NV_DATA,
  output logic [7:0]  O_NV_DATA
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_VB = 3'd1;
`ifdef DKONG_HS_SIGCHK_EN
  localparam logic [2:0] S_SIG_A   = 3'd2;
  localparam logic [2:0] S_SIG_B   = 3'd3;
`endif
  localparam logic [2:0] S_X_ADDR  = 3'd4;
  localparam logic [2:0] S_X_WAIT  = 3'd5;
  localparam logic [2:0] S_X_DATA  = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [5:0] LAST_IDX = 6'(LEN - 1);

  logic [2:0] state;
  logic       is_save;
  logic [5:0] idx;
  logic       vb_q;
  logic       err_q;
  logic [7:0] buffer [0:63];
  logic [7:0] nv_q;
  logic       vb_rise;
  logic       xfer;
  logic       sig_st;

  assign vb_rise = I_VBLANK & ~vb_q;

`ifdef DKONG_HS_SIGCHK_EN
  logic [15:0] frame_cnt;
  logic        sig_a_ok;
  assign sig_st = (state == S_SIG_A) || (state == S_SIG_B);
`else
  logic unused_cfg;
  assign unused_cfg = ^{SIG_FIRST, SIG_LAST, 32'(TIMEOUT_FRAMES)};
  assign sig_st     = 1'b0;
`endif

  always_ff @(posedge I_CLK_24576M) begin
    if (I_RESET) begin
      state   <= S_IDLE;
      is_save <= 1'b0;
      idx     <= '0;
      err_q   <= 1'b0;
      vb_q    <= 1'b0;
`ifdef DKONG_HS_SIGCHK_EN
      frame_cnt <= '0;
      sig_a_ok  <= 1'b0;
`endif
    end else begin
      vb_q <= I_VBLANK;
      case (state)
        S_IDLE: begin
          if (I_RESTORE_REQ) begin
            state   <= S_WAIT_VB;
            is_save <= 1'b0;
            idx     <= '0;
            err_q   <= 1'b0;
`ifdef DKONG_HS_SIGCHK_EN
            frame_cnt <= '0;
`endif
          end else if (I_SAVE_REQ) begin
            state   <= S_X_ADDR;
            is_save <= 1'b1;
            idx     <= '0;
            err_q   <= 1'b0;
          end
        end
        S_WAIT_VB: begin
          if (vb_rise) begin
`ifdef DKONG_HS_SIGCHK_EN
            frame_cnt <= frame_cnt + 16'd1;
            state     <= S_SIG_A;
`else
            state     <= S_X_ADDR;
`endif
          end
        end
`ifdef DKONG_HS_SIGCHK_EN
        S_SIG_A: begin
          sig_a_ok <= (I_HS_DATA_OUT == SIG_FIRST);
          state    <= S_SIG_B;
        end
        S_SIG_B: begin
          if (sig_a_ok && (I_HS_DATA_OUT == SIG_LAST)) begin
            state <= S_X_ADDR;
          end else if (frame_cnt >= 16'(TIMEOUT_FRAMES)) begin
            // gave up: finish without ever touching game RAM
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_WAIT_VB;
          end
        end
`endif
        S_X_ADDR: state <= S_X_WAIT;
        S_X_WAIT: state <= S_X_DATA;
        S_X_DATA: begin
          if (idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 6'd1;
            state <= S_X_ADDR;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Buffer is deliberately outside reset so host data survives a game reset.
  // Save data has priority; host writes are only honoured while idle.
  always_ff @(posedge I_CLK_24576M) begin
    if (state == S_X_DATA && is_save) begin
      buffer[idx] <= I_HS_DATA_OUT;
    end else if (I_NV_WR && state == S_IDLE) begin
      buffer[I_NV_ADDR] <= I_NV_DATA;
    end
    nv_q <= buffer[I_NV_ADDR];
  end

  assign xfer = (state == S_X_ADDR) || (state == S_X_WAIT) || (state == S_X_DATA);

  always_comb begin
    O_HS_ADDRESS = '0;
`ifdef DKONG_HS_SIGCHK_EN
    if (state == S_SIG_A) O_HS_ADDRESS = START_ADDR;
    if (state == S_SIG_B) O_HS_ADDRESS = START_ADDR + 16'(LEN - 1);
`endif
    if (xfer) O_HS_ADDRESS = START_ADDR + {10'd0, idx};
  end

  assign O_HS_DATA_IN = (xfer && !is_save) ? buffer[idx] : 8'h00;
  assign O_HS_WRITE   = (state == S_X_ADDR) && !is_save;
  assign O_HS_ACCESS  = xfer || sig_st;
  assign O_PAUSE      = O_HS_ACCESS;
  assign O_BUSY       = (state != S_IDLE);
  assign O_DONE       = (state == S_DONE);
  assign O_ERR        = err_q;
  assign O_NV_DATA    = nv_q;

endmodule

// File: tb/tb_dkong_hiscore_ctrl.sv
// Bench for dkong_hiscore_ctrl with LEN=4 at 6100, signature 11/44, timeout 3.
// Game RAM is a 16-byte array behind the port; host buffer is mirrored in nvbuf.
module tb_dkong_hiscore_ctrl;
  localparam int          LEN = 4;
  localparam logic [15:0] SA  = 16'h6100;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblank, restore_req, save_req;
  logic        busy, done, err, pause;
  logic [15:0] hs_addr;
  logic [7:0]  hs_din, hs_dout;
  logic        hs_wr, hs_acc;
  logic [5:0]  nv_addr;
  logic        nv_wr;
  logic [7:0]  nv_data, nv_q;

  dkong_hiscore_ctrl #(.START_ADDR(SA), .LEN(LEN), .SIG_FIRST(8'h11),
                       .SIG_LAST(8'h44), .TIMEOUT_FRAMES(3)) dut (
    .I_CLK_24576M(clk), .I_RESET(rst), .I_VBLANK(vblank),
    .I_RESTORE_REQ(restore_req), .I_SAVE_REQ(save_req),
    .O_BUSY(busy), .O_DONE(done), .O_ERR(err), .O_PAUSE(pause),
    .O_HS_ADDRESS(hs_addr), .O_HS_DATA_IN(hs_din), .I_HS_DATA_OUT(hs_dout),
    .O_HS_WRITE(hs_wr), .O_HS_ACCESS(hs_acc),
    .I_NV_ADDR(nv_addr), .I_NV_WR(nv_wr), .I_NV_DATA(nv_data), .O_NV_DATA(nv_q));

  always #5 clk = ~clk;

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;

  logic [7:0] gram  [0:15];
  logic [7:0] nvbuf [0:63];
  wr_t        wr_q[$];
  int errors = 0, checks = 0;
  int done_cnt = 0, viol = 0, cyc = 0, first_acc_cyc = 0, done_cyc = 0;
  logic acc_prev = 1'b0;

  assign hs_dout = (hs_addr[15:4] == SA[15:4]) ? gram[hs_addr[3:0]] : 8'hEE;

  // Per-cycle observer: game RAM writes, done pulses, access/pause agreement.
  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (hs_acc === 1'b1 && !acc_prev) first_acc_cyc = cyc;
    acc_prev = (hs_acc === 1'b1);
    if (pause !== hs_acc) viol++;
    if (hs_wr === 1'b1) begin
      if (hs_acc !== 1'b1) viol++;
      wr_q.push_back('{hs_addr, hs_din});
      if (hs_addr[15:4] == SA[15:4]) gram[hs_addr[3:0]] = hs_din;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic nv_write(input logic [5:0] a, input logic [7:0] d);
    nv_addr = a; nv_data = d; nv_wr = 1'b1; step(); nv_wr = 1'b0;
  endtask

  task automatic nv_read(input logic [5:0] a, output logic [7:0] d);
    nv_addr = a; step(); d = nv_q;
  endtask

  task automatic pulse_req(input logic r, input logic s);
    restore_req = r; save_req = s; step(); restore_req = 1'b0; save_req = 1'b0;
  endtask

  task automatic vb_edge();
    vblank = 1'b1; step(2); vblank = 1'b0; step(3);
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt > base) begin ok = 1; break; end
      step();
    end
    step();
  endtask

  task automatic set_sig();
    gram[0] = 8'h11; gram[3] = 8'h44;
    gram[1] = 8'($urandom); gram[2] = 8'($urandom);
  endtask

  task automatic check_writes(input string nm);
    checks++;
    if (wr_q.size() != LEN) begin
      errors++; $display("FAIL %s write_count got=%0d exp=%0d", nm, wr_q.size(), LEN);
    end else begin
      for (int i = 0; i < LEN; i++) begin
        checks++;
        if (wr_q[i].a !== SA + 16'(i) || wr_q[i].d !== nvbuf[i]) begin
          errors++;
          $display("FAIL %s write%0d got=%h:%h exp=%h:%h", nm, i, wr_q[i].a, wr_q[i].d,
                   SA + 16'(i), nvbuf[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(2);
    checks++;
    if ({busy, done, err, pause, hs_wr, hs_acc, hs_addr, hs_din} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b%b%b%b %h %h exp=all zero",
               busy, done, err, pause, hs_wr, hs_acc, hs_addr, hs_din);
    end
    rst = 1'b0; step(2);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%b done=%b exp=0 0", busy, done);
    end
  endtask

  task automatic test_nv_rw();
    logic [7:0] d;
    for (int i = 0; i < 64; i++) begin
      nvbuf[i] = 8'($urandom); nv_write(6'(i), nvbuf[i]);
    end
    for (int k = 0; k < 8; k++) begin
      int a = int'($urandom_range(0, 63));
      nv_read(6'(a), d);
      checks++;
      if (d !== nvbuf[a]) begin
        errors++; $display("FAIL nv_read addr=%0d got=%h exp=%h", a, d, nvbuf[a]);
      end
    end
  endtask

  task automatic test_save(input bit fixed);
    bit ok; int base; logic [7:0] d;
    for (int i = 0; i < LEN; i++)
      gram[i] = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
    wr_q.delete(); base = done_cnt;
    pulse_req(1'b0, 1'b1);
    checks++;
    if (busy !== 1'b1 || hs_acc !== 1'b1) begin
      errors++; $display("FAIL save_start busy=%b access=%b exp=1 1", busy, hs_acc);
    end
    wait_done(base, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL save_done got=timeout exp=done"); end
    checks++;
    if (done_cyc - first_acc_cyc != 3 * LEN) begin
      errors++; $display("FAIL save_latency got=%0d exp=%0d", done_cyc - first_acc_cyc, 3 * LEN);
    end
    checks++;
    if (wr_q.size() != 0 || err !== 1'b0) begin
      errors++; $display("FAIL save_nowrite writes=%0d err=%b exp=0 0", wr_q.size(), err);
    end
    for (int i = 0; i < LEN; i++) begin
      nvbuf[i] = gram[i];
      nv_read(6'(i), d);
      checks++;
      if (d !== nvbuf[i]) begin
        errors++; $display("FAIL save_readback addr=%0d got=%h exp=%h", i, d, nvbuf[i]);
      end
    end
  endtask

  task automatic test_restore();
    bit ok; int base;
    for (int i = 0; i < LEN; i++) begin nvbuf[i] = 8'($urandom); nv_write(6'(i), nvbuf[i]); end
    set_sig(); wr_q.delete(); base = done_cnt;
    pulse_req(1'b1, 1'b0);
    step(5);
    checks++;
    if (busy !== 1'b1 || hs_acc !== 1'b0 || wr_q.size() != 0) begin
      errors++; $display("FAIL restore_wait busy=%b access=%b writes=%0d exp=1 0 0",
                         busy, hs_acc, wr_q.size());
    end
    vb_edge();
    wait_done(base, ok);
    checks++;
    if (!ok || err !== 1'b0) begin
      errors++; $display("FAIL restore_done done=%0d err=%b exp=1 0", ok, err);
    end
    check_writes("restore");
  endtask

  task automatic test_timeout();
    bit ok; int base;
    gram[0] = 8'h5A; wr_q.delete(); base = done_cnt;
    pulse_req(1'b1, 1'b0);
`ifdef DKONG_HS_SIGCHK_EN
    for (int k = 1; k <= 3; k++) begin
      vb_edge();
      if (k < 3) begin
        checks++;
        if (done_cnt != base || busy !== 1'b1) begin
          errors++; $display("FAIL timeout_early edge=%0d done=%0d busy=%b exp=0 1",
                             k, done_cnt - base, busy);
        end
      end
    end
    wait_done(base, ok);
    checks++;
    if (!ok || err !== 1'b1 || wr_q.size() != 0) begin
      errors++; $display("FAIL timeout done=%0d err=%b writes=%0d exp=1 1 0", ok, err, wr_q.size());
    end
    step(3);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    base = done_cnt;
    pulse_req(1'b0, 1'b1);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", err); end
    wait_done(base, ok);
    for (int i = 0; i < LEN; i++) nvbuf[i] = gram[i];
`else
    vb_edge();
    wait_done(base, ok);
    checks++;
    if (!ok || err !== 1'b0) begin
      errors++; $display("FAIL nosig_restore done=%0d err=%b exp=1 0", ok, err);
    end
    check_writes("nosig_restore");
`endif
  endtask

  task automatic test_both_req();
    bit ok; int base;
    set_sig(); wr_q.delete(); base = done_cnt;
    pulse_req(1'b1, 1'b1);
    step(3);
    checks++;
    if (busy !== 1'b1 || hs_acc !== 1'b0) begin
      errors++; $display("FAIL both_req busy=%b access=%b exp=1 0", busy, hs_acc);
    end
    pulse_req(1'b0, 1'b1);
    step(3);
    checks++;
    if (hs_acc !== 1'b0) begin errors++; $display("FAIL save_ignored access=%b exp=0", hs_acc); end
    vb_edge();
    wait_done(base, ok);
    check_writes("both_req");
    step(10);
    checks++;
    if (busy !== 1'b0 || done_cnt != base + 1) begin
      errors++; $display("FAIL no_queue busy=%b dones=%0d exp=0 1", busy, done_cnt - base);
    end
  endtask

  task automatic test_nv_busy();
    bit ok; int base; logic [7:0] d, oldv, newv;
    set_sig(); wr_q.delete(); base = done_cnt;
    oldv = nvbuf[1]; newv = ~oldv;
    pulse_req(1'b1, 1'b0);
    step(2);
    nv_write(6'd1, newv);
    vb_edge();
    wait_done(base, ok);
    check_writes("nv_busy");
    nv_read(6'd1, d);
    checks++;
    if (d !== oldv) begin errors++; $display("FAIL nv_busy_ignored got=%h exp=%h", d, oldv); end
    nv_write(6'd1, newv); nvbuf[1] = newv;
    nv_read(6'd1, d);
    checks++;
    if (d !== newv) begin errors++; $display("FAIL nv_idle_write got=%h exp=%h", d, newv); end
  endtask

  task automatic test_reset_mid();
    int base; logic [7:0] d;
    for (int i = 0; i < LEN; i++) begin nvbuf[i] = 8'($urandom); nv_write(6'(i), nvbuf[i]); end
    set_sig(); wr_q.delete(); base = done_cnt;
    pulse_req(1'b1, 1'b0);
    step(2);
    vblank = 1'b1;
    for (int i = 0; i < 50 && wr_q.size() < 2; i++) step();
    checks++;
    if (wr_q.size() != 2) begin
      errors++; $display("FAIL mid_reach writes=%0d exp=2", wr_q.size());
    end
    rst = 1'b1; step();
    checks++;
    if ({busy, done, err, pause, hs_wr, hs_acc, hs_addr, hs_din} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got=%b%b%b%b%b%b %h %h exp=all zero",
                         busy, done, err, pause, hs_wr, hs_acc, hs_addr, hs_din);
    end
    rst = 1'b0; vblank = 1'b0;
    step(20);
    checks++;
    if (done_cnt != base || wr_q.size() != 2) begin
      errors++; $display("FAIL mid_abort dones=%0d writes=%0d exp=0 2", done_cnt - base, wr_q.size());
    end
    for (int i = 0; i < LEN; i++) begin
      nv_read(6'(i), d);
      checks++;
      if (d !== nvbuf[i]) begin
        errors++; $display("FAIL mid_buffer addr=%0d got=%h exp=%h", i, d, nvbuf[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; vblank = 1'b0; restore_req = 1'b0; save_req = 1'b0;
    nv_addr = '0; nv_wr = 1'b0; nv_data = '0;
    for (int i = 0; i < 16; i++) gram[i] = 8'($urandom);
    test_reset();
    test_nv_rw();
    test_save(1'b1);
    test_save(1'b0);
    test_restore();
    test_timeout();
    test_both_req();
    test_nv_busy();
    test_reset_mid();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL port_protocol violations=%0d exp=0", viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
